// File: rtl/dm_arbiter.sv
// dm_arbiter: shares a single-port data memory between port 0 (CPU MEM stage)
// and port 1 (DMA/debug loader). It grants at most one access per cycle and
// returns a registered response one cycle after the grant.
// Optional build macro: DM_ARB_CPU_PRIO_EN gives port 0 fixed priority, with a
// starvation counter that forces a port 1 grant after STARVE_MAX waiting cycles.
module dm_arbiter #(
    parameter int unsigned DM_WORDS   = 4096,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0,
    input  logic        i_we0,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_wdata0,
    output logic        o_gnt0,
    output logic        o_resp0,
    output logic [31:0] o_rdata0,
    output logic        o_err0,
    input  logic        i_req1,
    input  logic        i_we1,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wdata1,
    output logic        o_gnt1,
    output logic        o_resp1,
    output logic [31:0] o_rdata1,
    output logic        o_err1,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_write_data,
    input  logic [31:0] i_read_data
);

    // First byte address past the end of memory; 33 bits so it cannot overflow
    localparam logic [32:0] LP_ADDR_LIMIT = 33'(DM_WORDS) * 33'd4;

    logic        w_err0;
    logic        w_err1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_sel_we;
    logic        w_sel_err;

    logic        r_resp0;
    logic        r_resp1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        r_err0;
    logic        r_err1;

    // Misaligned or out-of-range addresses are granted but never write memory
    assign w_err0 = (i_addr0[1:0] != 2'b00) || ({1'b0, i_addr0} >= LP_ADDR_LIMIT);
    assign w_err1 = (i_addr1[1:0] != 2'b00) || ({1'b0, i_addr1} >= LP_ADDR_LIMIT);

`ifdef DM_ARB_CPU_PRIO_EN
    localparam int unsigned LP_CW = $clog2(STARVE_MAX + 1);

    logic [LP_CW-1:0] r_starve;
    logic             w_starved;

    assign w_starved = (r_starve >= LP_CW'(STARVE_MAX));

    // Fixed priority to port 0 unless port 1 has waited STARVE_MAX cycles
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_reset) begin
            if (i_req1 && w_starved) begin
                w_gnt1 = 1'b1;
            end else if (i_req0) begin
                w_gnt0 = 1'b1;
            end else if (i_req1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    // Starvation counter: counts cycles port 1 waits, cleared by its grant
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve <= '0;
        end else if (w_gnt1) begin
            r_starve <= '0;
        end else if (i_req1 && !w_starved) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    logic r_last_grant;

    // Round-robin: on conflict the port that did not win last time goes next
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_reset) begin
            if (i_req0 && i_req1) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = !r_last_grant;
            end else begin
                w_gnt0 = i_req0;
                w_gnt1 = i_req1;
            end
        end
    end

    // Last-grant register; reset to 1 so port 0 wins the first conflict
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= 1'b1;
        end else if (w_gnt0) begin
            r_last_grant <= 1'b0;
        end else if (w_gnt1) begin
            r_last_grant <= 1'b1;
        end
    end
`endif

    // Memory-side mux: follows port 1 only when it is granted
    always_comb begin
        o_mem_addr   = w_gnt1 ? i_addr1 : i_addr0;
        o_write_data = w_gnt1 ? i_wdata1 : i_wdata0;
        w_sel_we     = w_gnt1 ? i_we1 : i_we0;
        w_sel_err    = w_gnt1 ? w_err1 : w_err0;
        o_mem_write  = (w_gnt0 || w_gnt1) && w_sel_we && !w_sel_err;
    end

    // Response registers: one-cycle pulse to the port granted last cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_resp0  <= 1'b0;
            r_resp1  <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_resp0 <= w_gnt0;
            r_resp1 <= w_gnt1;
            if (w_gnt0) begin
                r_rdata0 <= (!i_we0 && !w_err0) ? i_read_data : 32'd0;
                r_err0   <= w_err0;
            end
            if (w_gnt1) begin
                r_rdata1 <= (!i_we1 && !w_err1) ? i_read_data : 32'd0;
                r_err1   <= w_err1;
            end
        end
    end

    assign o_gnt0   = w_gnt0;
    assign o_gnt1   = w_gnt1;
    assign o_resp0  = r_resp0;
    assign o_resp1  = r_resp1;
    assign o_rdata0 = r_rdata0;
    assign o_rdata1 = r_rdata1;
    assign o_err0   = r_err0;
    assign o_err1   = r_err1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: directed scenarios followed by random two-port
// traffic, checked against a transaction-level reference model and a
// response scoreboard.
module tb_dm_arbiter;

    localparam int unsigned DM_WORDS   = 4096;
    localparam int unsigned STARVE_MAX = 8;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];

    logic        o_gnt0, o_resp0, o_err0, o_gnt1, o_resp1, o_err1, o_mem_write;
    logic [31:0] o_rdata0, o_rdata1, o_mem_addr, o_write_data, read_data;

    // Memory the DUT drives, and an independent shadow kept by the model
    logic [31:0] tb_mem [DM_WORDS];
    logic [31:0] model_mem [DM_WORDS];

    resp_t exp_q0[$];
    resp_t exp_q1[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    last_served = 1;
    int    starve = 0;
    bit    granted [2];

    always #5 clk = ~clk;

    dm_arbiter #(.DM_WORDS(DM_WORDS), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req0(req[0]), .i_we0(we[0]), .i_addr0(addr[0]), .i_wdata0(wdata[0]),
        .o_gnt0(o_gnt0), .o_resp0(o_resp0), .o_rdata0(o_rdata0), .o_err0(o_err0),
        .i_req1(req[1]), .i_we1(we[1]), .i_addr1(addr[1]), .i_wdata1(wdata[1]),
        .o_gnt1(o_gnt1), .o_resp1(o_resp1), .o_rdata1(o_rdata1), .o_err1(o_err1),
        .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
        .o_write_data(o_write_data), .i_read_data(read_data)
    );

    assign read_data = tb_mem[o_mem_addr[13:2]];

    always @(posedge clk) begin
        if (o_mem_write === 1'b1) tb_mem[o_mem_addr[13:2]] <= o_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= DM_WORDS * 4);
    endfunction

    // Reference model for one cycle, evaluated mid-cycle with inputs stable
    task automatic eval();
        bit    e0, e1, exp_we;
        int    w;
        resp_t r;
        e0 = 0;
        e1 = 0;
        if (!reset) begin
`ifdef DM_ARB_CPU_PRIO_EN
            if (req[1] && starve >= STARVE_MAX) e1 = 1;
            else if (req[0]) e0 = 1;
            else if (req[1]) e1 = 1;
`else
            if (req[0] && req[1]) begin
                if (last_served == 1) e0 = 1;
                else e1 = 1;
            end else begin
                e0 = req[0];
                e1 = req[1];
            end
`endif
        end
        chk("gnt0", {31'd0, o_gnt0}, {31'd0, e0});
        chk("gnt1", {31'd0, o_gnt1}, {31'd0, e1});
        w = e1 ? 1 : 0;
        exp_we = (e0 || e1) && we[w] && !addr_bad(addr[w]);
        chk("mem_write", {31'd0, o_mem_write}, {31'd0, exp_we});
        if (e0 || e1) begin
            chk("mem_addr", o_mem_addr, addr[w]);
            if (exp_we) chk("write_data", o_write_data, wdata[w]);
            r.err   = addr_bad(addr[w]);
            r.rdata = (!we[w] && !r.err) ? model_mem[addr[w] / 4] : 32'd0;
            if (w == 0) exp_q0.push_back(r);
            else exp_q1.push_back(r);
            if (exp_we) model_mem[addr[w] / 4] = wdata[w];
            last_served = w;
        end
        if (reset) begin
            last_served = 1;
            starve = 0;
        end else if (e1) begin
            starve = 0;
        end else if (req[1]) begin
            starve++;
        end
        granted[0] = e0;
        granted[1] = e1;
    endtask

    // One cycle: check at the falling edge, then step to just after the next rising edge
    task automatic tick();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
        req[p] = r;
        we[p] = w;
        addr[p] = a;
        wdata[p] = d;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
        if (sel == 1) return 32'h4000 + $urandom_range(0, 255) * 4;
        return $urandom_range(0, 15) * 4;
    endfunction

    // Response monitor: pops the expected response whenever a pulse appears
    always @(negedge clk) begin
        resp_t r;
        if (o_resp0 === 1'b1) begin
            if (exp_q0.size() == 0) begin
                chk("resp0_unexpected", {31'd0, o_resp0}, 32'd0);
            end else begin
                r = exp_q0.pop_front();
                chk("rdata0", o_rdata0, r.rdata);
                chk("err0", {31'd0, o_err0}, {31'd0, r.err});
            end
        end
        if (o_resp1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                chk("resp1_unexpected", {31'd0, o_resp1}, 32'd0);
            end else begin
                r = exp_q1.pop_front();
                chk("rdata1", o_rdata1, r.rdata);
                chk("err1", {31'd0, o_err1}, {31'd0, r.err});
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(DM_WORDS); i++) begin
            tb_mem[i] = 32'd0;
            model_mem[i] = 32'd0;
        end
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("reset_resp0", {31'd0, o_resp0}, 32'd0);
        chk("reset_resp1", {31'd0, o_resp1}, 32'd0);
        chk("reset_rdata0", o_rdata0, 32'd0);
        chk("reset_err1", {31'd0, o_err1}, 32'd0);
        reset = 1'b0;

        // Write then read-after-write on the other port
        set_port(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_port(1, 1'b1, 1'b0, 32'h10, 32'd0);
        tick();
        chk("raw_resp1", {31'd0, o_resp1}, 32'd1);
        chk("raw_rdata1", o_rdata1, 32'hDEADBEEF);
        set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Both ports held for four cycles
        set_port(0, 1'b1, 1'b1, 32'h40, 32'h11111111);
        set_port(1, 1'b1, 1'b0, 32'h40, 32'd0);
        repeat (4) tick();
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Error cases: misaligned write, out-of-range read
        set_port(0, 1'b1, 1'b1, 32'h12, 32'hCAFEF00D);
        tick();
        chk("misaligned_err0", {31'd0, o_err0}, 32'd1);
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_port(1, 1'b1, 1'b0, 32'h4000, 32'd0);
        tick();
        chk("range_err1", {31'd0, o_err1}, 32'd1);
        chk("range_rdata1", o_rdata1, 32'd0);
        set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset in the same cycle as a write suppresses it
        reset = 1'b1;
        set_port(0, 1'b1, 1'b1, 32'h20, 32'h55AA55AA);
        tick();
        reset = 1'b0;
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("reset_write_no_resp0", {31'd0, o_resp0}, 32'd0);
        set_port(0, 1'b1, 1'b0, 32'h20, 32'd0);
        tick();
        chk("after_reset_resp0", {31'd0, o_resp0}, 32'd1);
        chk("after_reset_rdata0", o_rdata0, 32'd0);
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Random traffic; requests stay stable until granted
        for (int k = 0; k < 600; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p] || granted[p]) begin
                    if ($urandom_range(0, 9) < 6)
                        set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                    else
                        set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
                end
            end
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) tick();
        chk("drain_q0", exp_q0.size(), 32'd0);
        chk("drain_q1", exp_q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
